// File: rtl/tx_packet_router_if.sv
// Word-stream bus between the USB packer, tx_packet_router and the per-channel RAMs.
// The packer side uses the master modport and the router uses the slave modport.
interface tx_packet_router_if #(
  parameter int NUM_CHAN = 2
);
  logic [31:0]       usbdata_final;
  logic              WR_final;
  logic [NUM_CHAN:0] have_space;
  logic [31:0]       ram_data;
  logic [NUM_CHAN:0] WR_channel;
  logic [NUM_CHAN:0] WR_done_channel;
  logic              dropped_packet;
  logic [4:0]        dropped_chan;
  logic [15:0]       dropped_count;

  modport master (
    output usbdata_final, WR_final, have_space,
    input  ram_data, WR_channel, WR_done_channel,
           dropped_packet, dropped_chan, dropped_count
  );

  modport slave (
    input  usbdata_final, WR_final, have_space,
    output ram_data, WR_channel, WR_done_channel,
           dropped_packet, dropped_chan, dropped_count
  );
endinterface

// File: rtl/tx_packet_router.sv
// Steers fixed-length packets from the USB packer into per-channel RAMs by header code.
// Define TX_ROUTER_DROP_STATS_EN to build the saturating dropped-packet counter.
module tx_packet_router #(
  parameter int         NUM_CHAN    = 2,
  parameter int         PKT_WORDS   = 128,
  parameter logic [4:0] CMD_CHAN_ID = 5'h1F
) (
  input logic               txclk,
  input logic               reset_n,
  tx_packet_router_if.slave bus
);
  localparam int NSLOT = NUM_CHAN + 1;
  localparam int CW    = $clog2(PKT_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUTE = 2'd1, DROP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [NSLOT-1:0] sel_q, sel_d;
  logic [NSLOT-1:0] hdr_slot;
  logic [CW-1:0]    word_cnt;
  logic [4:0]       hdr_code;
  logic             hdr_accept;
  logic             last_word;
  logic             wr_en;
  logic             drop_hdr;

  logic [31:0]      ram_data_q;
  logic [NSLOT-1:0] wr_ch_q;
  logic [NSLOT-1:0] done_pend_q;
  logic [NSLOT-1:0] done_q;
  logic             drop_pulse_q;
  logic [4:0]       drop_chan_q;

  assign hdr_code  = bus.usbdata_final[20:16];
  assign last_word = bus.WR_final && (word_cnt == CW'(PKT_WORDS - 1));

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    hdr_slot = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (hdr_code == 5'(i)) hdr_slot[i] = 1'b1;
    end
    if (hdr_slot == '0 && hdr_code == CMD_CHAN_ID) hdr_slot[NUM_CHAN] = 1'b1;
  end

  // Only the selected slot's space flag matters, and only in the header cycle.
  assign hdr_accept = |(hdr_slot & bus.have_space);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wr_en    = 1'b0;
    drop_hdr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.WR_final) begin
          if (hdr_accept) begin
            state_d = ROUTE;
            sel_d   = hdr_slot;
            wr_en   = 1'b1;
          end else begin
            state_d  = DROP;
            drop_hdr = 1'b1;
          end
        end
      end
      ROUTE: begin
        wr_en = bus.WR_final;
        if (last_word) state_d = IDLE;
      end
      DROP: begin
        if (last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt     <= '0;
      ram_data_q   <= '0;
      wr_ch_q      <= '0;
      done_pend_q  <= '0;
      done_q       <= '0;
      drop_pulse_q <= 1'b0;
      drop_chan_q  <= '0;
    end else begin
      // PKT_WORDS is a power of two, so the natural wrap returns the count to 0.
      if (bus.WR_final) word_cnt <= word_cnt + CW'(1);
      if (wr_en) ram_data_q <= bus.usbdata_final;
      wr_ch_q <= wr_en ? sel_d : '0;
      // Done is staged on its own so a header right behind the last word can retarget sel_q.
      done_pend_q  <= (state_q == ROUTE && last_word) ? sel_q : '0;
      done_q       <= done_pend_q;
      drop_pulse_q <= drop_hdr;
      if (drop_hdr) drop_chan_q <= hdr_code;
    end
  end

  assign bus.ram_data        = ram_data_q;
  assign bus.WR_channel      = wr_ch_q;
  assign bus.WR_done_channel = done_q;
  assign bus.dropped_packet  = drop_pulse_q;
  assign bus.dropped_chan    = drop_chan_q;

`ifdef TX_ROUTER_DROP_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (drop_pulse_q && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.dropped_count = drop_cnt_q;
`else
  assign bus.dropped_count = 16'h0000;
`endif

endmodule
